// File: rtl/scemi_msg_out_serializer_if.sv
// Message-in / link-out bundle for the SCE-MI output message port.
// Optional link_parity signal present when SCEMI_OUT_PARITY_EN is defined.
interface scemi_msg_out_serializer_if #(
   parameter int unsigned PortWidth = 32,
   parameter int unsigned LinkWidth = 16
);
   logic                 TransmitReady;
   logic                 ReceiveReady;
   logic [PortWidth-1:0] Message;
   logic                 link_valid;
   logic                 link_ready;
   logic [LinkWidth-1:0] link_data;
   logic                 link_last;
`ifdef SCEMI_OUT_PARITY_EN
   logic                 link_parity;
`endif

   // Serializer side: accepts messages, drives the link
   modport master (
`ifdef SCEMI_OUT_PARITY_EN
      output link_parity,
`endif
      input  TransmitReady, Message, link_ready,
      output ReceiveReady, link_valid, link_data, link_last
   );

   // Environment side: DUT logic pushing messages and host proxy taking beats
   modport slave (
`ifdef SCEMI_OUT_PARITY_EN
      input  link_parity,
`endif
      output TransmitReady, Message, link_ready,
      input  ReceiveReady, link_valid, link_data, link_last
   );
endinterface

// File: rtl/scemi_msg_out_serializer.sv
// SCE-MI output message port: buffers PortWidth-bit messages in a Depth-entry
// FIFO and serializes them LSB-first onto a LinkWidth valid/ready/last link.
// Optional feature macro: SCEMI_OUT_PARITY_EN (adds link_parity on the link).
// Legal configurations: 1 <= LinkWidth <= PortWidth, Depth a power of 2, >= 2.
module scemi_msg_out_serializer #(
   parameter int unsigned PortWidth = 32,
   parameter int unsigned LinkWidth = 16,
   parameter int unsigned Depth     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   scemi_msg_out_serializer_if.master bus,
   output logic [15:0]                msg_count
);

   localparam int unsigned NBeats = (PortWidth + LinkWidth - 1) / LinkWidth;
   localparam int unsigned ShiftW = NBeats * LinkWidth;
   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned BeatW  = (NBeats > 1) ? $clog2(NBeats) : 1;

   typedef enum logic {S_IDLE, S_SEND} state_e;

   logic [PortWidth-1:0] fifo_q [Depth];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      count_q, count_d;
   state_e               state_q, state_d;
   logic [ShiftW-1:0]    shift_q, shift_d, head;
   logic [BeatW-1:0]     beat_q, beat_d;
   logic [15:0]          msg_count_q, msg_count_d;
   logic                 rr_q, rr_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic                 push, pop;
`ifdef SCEMI_OUT_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   // Next-state: FIFO bookkeeping and beat serializer
   always_comb begin
      push        = bus.TransmitReady && rr_q;
      pop         = 1'b0;
      state_d     = state_q;
      shift_d     = shift_q;
      beat_d      = beat_q;
      msg_count_d = msg_count_q;
      head        = ShiftW'(fifo_q[rd_ptr_q]);
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = head;
               beat_d  = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.link_ready) begin
               if (beat_q == BeatW'(NBeats - 1)) begin
                  msg_count_d = msg_count_q + 16'd1;
                  // Reload straight from the FIFO so messages stream without a bubble
                  if (count_q != '0) begin
                     pop     = 1'b1;
                     shift_d = head;
                     beat_d  = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  shift_d = shift_q >> LinkWidth;
                  beat_d  = beat_q + BeatW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      count_d  = count_q + CntW'(push) - CntW'(pop);
      rr_d     = (count_d != CntW'(Depth));
      valid_d  = (state_d == S_SEND);
      last_d   = valid_d && (beat_d == BeatW'(NBeats - 1));
`ifdef SCEMI_OUT_PARITY_EN
      parity_d = ^shift_d[LinkWidth-1:0];
`endif
   end

   // State and output registers; reset abandons any partial message and flushes the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         beat_q      <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rr_q        <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         msg_count_q <= '0;
`ifdef SCEMI_OUT_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         beat_q      <= beat_d;
         count_q     <= count_d;
         rr_q        <= rr_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         msg_count_q <= msg_count_d;
`ifdef SCEMI_OUT_PARITY_EN
         parity_q    <= parity_d;
`endif
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   // FIFO storage; pointers are reset separately so contents need no reset
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= bus.Message;
   end

   assign bus.ReceiveReady = rr_q;
   assign bus.link_valid   = valid_q;
   assign bus.link_data    = shift_q[LinkWidth-1:0];
   assign bus.link_last    = last_q;
   assign msg_count        = msg_count_q;
`ifdef SCEMI_OUT_PARITY_EN
   assign bus.link_parity  = parity_q;
`endif

endmodule

// File: tb/tb_scemi_msg_out_serializer.sv
// Bench for scemi_msg_out_serializer: directed steps plus random traffic,
// checked against a queue-of-beats reference model.
module tb_scemi_msg_out_serializer;

   localparam int unsigned PW    = 32;
   localparam int unsigned LW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NB    = (PW + LW - 1) / LW;

   typedef struct packed {
      logic [LW-1:0] data;
      logic          last;
   } beat_t;

   logic        clk;
   logic        rst;
   logic [15:0] msg_count;

   scemi_msg_out_serializer_if #(.PortWidth(PW), .LinkWidth(LW)) bus ();

   scemi_msg_out_serializer #(.PortWidth(PW), .LinkWidth(LW), .Depth(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .msg_count (msg_count)
   );

   always #5 clk = ~clk;

   beat_t       exp_q[$];
   logic [15:0] exp_cnt;
   int          checks;
   int          errors;
   int          accepted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: record what the edge will transfer, advance, then check against the model
   task automatic tick();
      logic          in_rst, hs, pu, stall;
      logic [LW-1:0] d;
      logic          l;
      beat_t         b;
      in_rst = rst;
      hs     = (bus.link_valid === 1'b1) && (bus.link_ready === 1'b1) && !in_rst;
      stall  = (bus.link_valid === 1'b1) && (bus.link_ready === 1'b0) && !in_rst;
      pu     = (bus.TransmitReady === 1'b1) && (bus.ReceiveReady === 1'b1) && !in_rst;
      d      = bus.link_data;
      l      = bus.link_last;
      if (pu) begin
         accepted++;
         for (int k = 0; k < int'(NB); k++) begin
            b.data = LW'(bus.Message >> (k * LW));
            b.last = (k == int'(NB) - 1);
            exp_q.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      if (in_rst) begin
         exp_q.delete();
         exp_cnt = '0;
      end
      if (hs) begin
         chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("beat_data", 32'(d), 32'(b.data));
            chk("beat_last", 32'(l), 32'(b.last));
            if (b.last) exp_cnt = exp_cnt + 16'd1;
         end
      end
      if (stall) begin
         chk("stall_valid", 32'(bus.link_valid), 32'd1);
         chk("stall_data", 32'(bus.link_data), 32'(d));
         chk("stall_last", 32'(bus.link_last), 32'(l));
      end
      chk("msg_count", 32'(msg_count), 32'(exp_cnt));
`ifdef SCEMI_OUT_PARITY_EN
      if (bus.link_valid === 1'b1 && exp_q.size() != 0)
         chk("parity", 32'(bus.link_parity), 32'(^exp_q[0].data));
`endif
   endtask

   // Run until the model has no beats pending and the link is idle (bounded)
   task automatic drain();
      for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.link_valid === 1'b1); i++) tick();
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      chk("drain_idle", 32'(bus.link_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, beats, gaps, acc0;
      logic started, took;
      clk               = 1'b0;
      rst               = 1'b1;
      bus.TransmitReady = 1'b0;
      bus.Message       = '0;
      bus.link_ready    = 1'b1;
      exp_cnt           = '0;
      checks            = 0;
      errors            = 0;
      accepted          = 0;

      // Reset held two cycles
      tick();
      tick();
      chk("rst_rr", 32'(bus.ReceiveReady), 32'd0);
      chk("rst_valid", 32'(bus.link_valid), 32'd0);
      chk("rst_data", 32'(bus.link_data), 32'd0);
      chk("rst_last", 32'(bus.link_last), 32'd0);
      chk("rst_count", 32'(msg_count), 32'd0);
`ifdef SCEMI_OUT_PARITY_EN
      chk("rst_parity", 32'(bus.link_parity), 32'd0);
`endif
      rst = 1'b0;
      tick();
      chk("rr_after_release", 32'(bus.ReceiveReady), 32'd1);

      // Single message, link always ready
      bus.TransmitReady = 1'b1;
      bus.Message       = 32'hDEADBEEF;
      tick();
      bus.TransmitReady = 1'b0;
      chk("latency_not_yet", 32'(bus.link_valid), 32'd0);
      tick();
      chk("one_valid", 32'(bus.link_valid), 32'd1);
      chk("one_beat0", 32'(bus.link_data), 32'hBEEF);
      chk("one_last0", 32'(bus.link_last), 32'd0);
      tick();
      chk("one_beat1", 32'(bus.link_data), 32'hDEAD);
      chk("one_last1", 32'(bus.link_last), 32'd1);
      tick();
      chk("one_idle", 32'(bus.link_valid), 32'd0);
      chk("one_count", 32'(msg_count), 32'd1);

      // Backpressure: beat held stable for five stalled cycles
      bus.link_ready    = 1'b0;
      bus.TransmitReady = 1'b1;
      bus.Message       = 32'h12345678;
      tick();
      bus.TransmitReady = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.link_valid), 32'd1);
         chk("bp_data", 32'(bus.link_data), 32'h5678);
         chk("bp_last", 32'(bus.link_last), 32'd0);
         tick();
      end
      bus.link_ready = 1'b1;
      tick();
      chk("bp_beat1", 32'(bus.link_data), 32'h1234);
      chk("bp_last1", 32'(bus.link_last), 32'd1);
      tick();
      chk("bp_idle", 32'(bus.link_valid), 32'd0);
      chk("bp_count", 32'(msg_count), 32'd2);

      // Full FIFO: 1 in the shift register plus DEPTH queued
      bus.link_ready    = 1'b0;
      acc0              = accepted;
      bus.TransmitReady = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         bus.Message = 32'(i);
         tick();
      end
      bus.TransmitReady = 1'b0;
      chk("full_accepted", 32'(accepted - acc0), 32'(DEPTH + 1));
      chk("full_rr", 32'(bus.ReceiveReady), 32'd0);
      bus.link_ready = 1'b1;
      drain();
      chk("full_count", 32'(msg_count), 32'd7);

      // Streaming: ten messages, no bubble between them
      idx     = 0;
      beats   = 0;
      gaps    = 0;
      started = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (idx < 10) begin
            bus.TransmitReady = 1'b1;
            bus.Message       = 32'(idx);
         end else begin
            bus.TransmitReady = 1'b0;
         end
         took = bus.TransmitReady && (bus.ReceiveReady === 1'b1);
         tick();
         if (took) idx++;
         if (bus.link_valid === 1'b1) begin
            started = 1'b1;
            beats++;
            chk("stream_last", 32'(bus.link_last), 32'(beats % 2 == 0));
         end else if (started && beats < 20) begin
            gaps++;
         end
      end
      chk("stream_pushed", 32'(idx), 32'd10);
      chk("stream_beats", 32'(beats), 32'd20);
      chk("stream_gaps", 32'(gaps), 32'd0);
      chk("stream_count", 32'(msg_count), 32'd17);

      // Random traffic against the model
      for (int c = 0; c < 300; c++) begin
         bus.TransmitReady = 1'($urandom_range(0, 1));
         bus.Message       = 32'($urandom);
         bus.link_ready    = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.TransmitReady = 1'b0;
      bus.link_ready    = 1'b1;
      drain();

      // Reset after first beat with two messages queued
      bus.link_ready    = 1'b0;
      bus.TransmitReady = 1'b1;
      bus.Message       = 32'hCAFEF00D;
      tick();
      bus.Message = 32'($urandom);
      tick();
      bus.Message = 32'($urandom);
      tick();
      bus.TransmitReady = 1'b0;
      chk("mid_beat0", 32'(bus.link_data), 32'hF00D);
      bus.link_ready = 1'b1;
      tick();
      chk("mid_beat1", 32'(bus.link_data), 32'hCAFE);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(bus.link_valid), 32'd0);
      chk("mid_rst_count", 32'(msg_count), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_quiet", 32'(bus.link_valid), 32'd0);
      end
      bus.TransmitReady = 1'b1;
      bus.Message       = 32'hA5A5_0F0F;
      tick();
      bus.TransmitReady = 1'b0;
      drain();
      chk("post_rst_count", 32'(msg_count), 32'd1);

`ifdef SCEMI_OUT_PARITY_EN
      // Parity of each beat
      bus.TransmitReady = 1'b1;
      bus.Message       = 32'h00070001;
      tick();
      bus.TransmitReady = 1'b0;
      tick();
      chk("par_beat0", 32'(bus.link_data), 32'h0001);
      chk("par_bit0", 32'(bus.link_parity), 32'd1);
      tick();
      chk("par_beat1", 32'(bus.link_data), 32'h0007);
      chk("par_bit1", 32'(bus.link_parity), 32'd1);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
